// File: rtl/mpsoc_msi_wb_pkg.sv
// Shared types and helpers for the Wishbone posted-write buffer bridge.
package mpsoc_msi_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_RD_ISSUE,
    ST_RD_RESP
  } wb_state_e;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int wb_level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mpsoc_msi_wb_fifo.sv
// Synchronous FIFO holding posted writes; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module mpsoc_msi_wb_fifo
  import mpsoc_msi_wb_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head_data,
  output logic                         full,
  output logic                         empty,
  output logic [wb_level_w(DEPTH)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = wb_level_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rptr];

  // NOTE: storage is deliberately left out of reset; only the pointers and
  // the level define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge wb_clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // NOTE: every register here uses <= so all state updates see the values
  // from before the edge, regardless of statement order.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/mpsoc_msi_wb_buffer.sv
// Wishbone classic bridge with a posted-write buffer; reads are ordered behind
// buffered writes. Define MPSOC_MSI_WB_BUFFER_TIMEOUT_EN to bound slave cycles.
module mpsoc_msi_wb_buffer
  import mpsoc_msi_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  input  logic [AW-1:0]                wbm_adr_i,
  input  logic [DW-1:0]                wbm_dat_i,
  input  logic [DW/8-1:0]              wbm_sel_i,
  input  logic                         wbm_we_i,
  input  logic                         wbm_cyc_i,
  input  logic                         wbm_stb_i,
  output logic [DW-1:0]                wbm_dat_o,
  output logic                         wbm_ack_o,
  output logic                         wbm_err_o,
  output logic [AW-1:0]                wbs_adr_o,
  output logic [DW-1:0]                wbs_dat_o,
  output logic [DW/8-1:0]              wbs_sel_o,
  output logic                         wbs_we_o,
  output logic                         wbs_cyc_o,
  output logic                         wbs_stb_o,
  input  logic [DW-1:0]                wbs_dat_i,
  input  logic                         wbs_ack_i,
  input  logic                         wbs_err_i,
  output logic                         wr_err_o,
  input  logic                         wr_err_clr_i,
  output logic [wb_level_w(DEPTH)-1:0] level_o
);

  localparam int SW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } wb_entry_t;

  wb_state_e     state;
  wb_entry_t     push_entry;
  wb_entry_t     head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          cs;
  logic          new_req;
  logic          xfer_done;
  logic          xfer_err;
  logic          timeout_hit;
  logic          pop;
  logic          wr_accept;
  logic          rd_req;
  logic          wr_start;
  logic          rd_start;
  logic          rd_abort;
  logic [AW-1:0] rd_adr;
  logic [SW-1:0] rd_sel;

  assign cs         = wbm_cyc_i & wbm_stb_i;
  assign new_req    = cs & ~wbm_ack_o & ~wbm_err_o;
  assign xfer_done  = wbs_cyc_o & (wbs_ack_i | wbs_err_i | timeout_hit);
  assign xfer_err   = wbs_err_i | timeout_hit;
  assign pop        = xfer_done & wbs_we_o;
  assign wr_accept  = new_req & wbm_we_i & (state == ST_IDLE) & (~fifo_full | pop);
  assign rd_req     = new_req & ~wbm_we_i & (state == ST_IDLE);
  assign push_entry = '{adr: wbm_adr_i, dat: wbm_dat_i, sel: wbm_sel_i};

  // A new slave cycle only starts from a low wbs_cyc_o, which guarantees the
  // idle gap between back-to-back transfers.
  assign wr_start = ~wbs_cyc_o & ~fifo_empty & ((state == ST_IDLE) | (state == ST_DRAIN));
  assign rd_start = ~wbs_cyc_o & fifo_empty & (state == ST_DRAIN);

  mpsoc_msi_wb_fifo #(
    .W     ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .push      (wr_accept),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

`ifdef MPSOC_MSI_WB_BUFFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = wbs_cyc_o & (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk) begin
    if (wb_rst || !wbs_cyc_o || xfer_done) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= ST_IDLE;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
      wr_err_o  <= 1'b0;
      rd_adr    <= '0;
      rd_sel    <= '0;
      rd_abort  <= 1'b0;
    end else begin
      wbm_ack_o <= wr_accept;
      wbm_err_o <= 1'b0;

      if (pop && xfer_err)   wr_err_o <= 1'b1;
      else if (wr_err_clr_i) wr_err_o <= 1'b0;

      if (xfer_done) begin
        wbs_cyc_o <= 1'b0;
        wbs_stb_o <= 1'b0;
      end

      if (wr_start) begin
        wbs_cyc_o <= 1'b1;
        wbs_stb_o <= 1'b1;
        wbs_we_o  <= 1'b1;
        wbs_adr_o <= head_entry.adr;
        wbs_dat_o <= head_entry.dat;
        wbs_sel_o <= head_entry.sel;
      end

      // A master that gives up mid-read still lets the slave read finish.
      if (!cs && (state == ST_DRAIN || state == ST_RD_ISSUE)) rd_abort <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            state    <= ST_DRAIN;
            rd_adr   <= wbm_adr_i;
            rd_sel   <= wbm_sel_i;
            rd_abort <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (rd_start) begin
            state     <= ST_RD_ISSUE;
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            wbs_we_o  <= 1'b0;
            wbs_adr_o <= rd_adr;
            wbs_dat_o <= '0;
            wbs_sel_o <= rd_sel;
          end
        end
        ST_RD_ISSUE: begin
          if (xfer_done) begin
            if (rd_abort || !cs) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_RD_RESP;
              wbm_ack_o <= ~xfer_err;
              wbm_err_o <= xfer_err;
              wbm_dat_o <= xfer_err ? '0 : wbs_dat_i;
            end
          end
        end
        ST_RD_RESP: begin
          state     <= ST_IDLE;
          wbm_dat_o <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_msi_wb_buffer.sv
// Directed self-checking bench for mpsoc_msi_wb_buffer with a small Wishbone
// slave model that logs every completed slave transfer.
module tb_mpsoc_msi_wb_buffer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH + 1);

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [AW-1:0] wbm_adr_i;
  logic [DW-1:0] wbm_dat_i;
  logic [3:0]    wbm_sel_i;
  logic          wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_ack_o, wbm_err_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [3:0]    wbs_sel_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [DW-1:0] wbs_dat_i;
  logic          wbs_ack_i, wbs_err_i;
  logic          wr_err_o, wr_err_clr_i;
  logic [LW-1:0] level_o;

  int vectors = 0;
  int miscompares = 0;

  // Slave model controls and transfer log
  logic          slv_ack_en;
  logic          slv_err_all;
  int            slv_err_idx;
  int            slv_done_n = 0;
  int            slv_cyc_cnt = 0;
  logic [31:0]   smem [64] = '{default: 32'h0};
  logic [31:0]   log_adr [$];
  logic [31:0]   log_dat [$];
  logic          log_we  [$];

  always #5 wb_clk = ~wb_clk;

  mpsoc_msi_wb_buffer #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(16)
  ) dut (
    .wb_clk       (wb_clk),
    .wb_rst       (wb_rst),
    .wbm_adr_i    (wbm_adr_i),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_sel_i    (wbm_sel_i),
    .wbm_we_i     (wbm_we_i),
    .wbm_cyc_i    (wbm_cyc_i),
    .wbm_stb_i    (wbm_stb_i),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_o    (wbm_ack_o),
    .wbm_err_o    (wbm_err_o),
    .wbs_adr_o    (wbs_adr_o),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_sel_o    (wbs_sel_o),
    .wbs_we_o     (wbs_we_o),
    .wbs_cyc_o    (wbs_cyc_o),
    .wbs_stb_o    (wbs_stb_o),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_i    (wbs_ack_i),
    .wbs_err_i    (wbs_err_i),
    .wr_err_o     (wr_err_o),
    .wr_err_clr_i (wr_err_clr_i),
    .level_o      (level_o)
  );

  assign wbs_err_i = wbs_cyc_o & wbs_stb_o & (slv_err_all | (slv_done_n == slv_err_idx));
  assign wbs_ack_i = wbs_cyc_o & wbs_stb_o & slv_ack_en & ~wbs_err_i;
  assign wbs_dat_i = smem[wbs_adr_o[7:2]];

  always @(posedge wb_clk) begin
    if (wbs_cyc_o) slv_cyc_cnt <= slv_cyc_cnt + 1;
    if (wbs_cyc_o && wbs_stb_o && (wbs_ack_i || wbs_err_i)) begin
      log_adr.push_back(wbs_adr_o);
      log_dat.push_back(wbs_dat_o);
      log_we.push_back(wbs_we_o);
      slv_done_n <= slv_done_n + 1;
      if (wbs_we_o && wbs_ack_i) smem[wbs_adr_o[7:2]] <= wbs_dat_o;
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic master_idle();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_we_i  = 1'b0;
  endtask

  task automatic post_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    wbm_adr_i = a;
    wbm_dat_i = d;
    wbm_sel_i = 4'hF;
    wbm_we_i  = 1'b1;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    tick();
    check({tag, "_ack"}, wbm_ack_o, 1);
    master_idle();
    tick();
  endtask

  task automatic start_read(input logic [31:0] a);
    wbm_adr_i = a;
    wbm_sel_i = 4'hF;
    wbm_we_i  = 1'b0;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
  endtask

  task automatic wait_idle_slave(input string tag);
    int n = 0;
    while ((level_o != 0 || wbs_cyc_o) && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, (n < 60), 1);
  endtask

  initial begin
    int base;
    int n;
    logic got;
    wb_rst = 1'b1;
    wr_err_clr_i = 1'b0;
    wbm_adr_i = '0;
    wbm_dat_i = '0;
    wbm_sel_i = '0;
    master_idle();
    slv_ack_en = 1'b1;
    slv_err_all = 1'b0;
    slv_err_idx = -1;
    tick();
    tick();
    check("rst_ack", wbm_ack_o, 0);
    check("rst_cyc", wbs_cyc_o, 0);
    check("rst_level", level_o, 0);
    check("rst_wr_err", wr_err_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    wb_rst = 1'b0;
    tick();

    // Reset in the middle of a stalled write drain
    slv_ack_en = 1'b0;
    post_write(32'h100, 32'h1111_0000, "rmd_w0");
    post_write(32'h104, 32'h1111_0001, "rmd_w1");
    post_write(32'h108, 32'h1111_0002, "rmd_w2");
    check("rmd_level3", level_o, 3);
    check("rmd_cyc_busy", wbs_cyc_o, 1);
    check("rmd_head_adr", wbs_adr_o, 32'h100);
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    check("rmd_cyc_drop", wbs_cyc_o, 0);
    check("rmd_level0", level_o, 0);
    check("rmd_wr_err", wr_err_o, 0);
    slv_ack_en = 1'b1;
    n = slv_cyc_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("rmd_no_slave", slv_cyc_cnt - n, 0);
    check("rmd_no_log", slv_done_n, 0);

    // Fill the buffer against a stalled slave
    slv_ack_en = 1'b0;
    base = slv_done_n;
    for (int i = 0; i < 4; i++) post_write(32'h40 + 32'(4 * i), 32'(i + 1), $sformatf("fill_w%0d", i + 1));
    check("fill_level4", level_o, 4);
    wbm_adr_i = 32'h50;
    wbm_dat_i = 32'h5;
    wbm_we_i  = 1'b1;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    tick();
    check("fill_w5_stall_a", wbm_ack_o, 0);
    check("fill_w5_level", level_o, 4);
    tick();
    check("fill_w5_stall_b", wbm_ack_o, 0);
    slv_ack_en = 1'b1;
    tick();
    slv_ack_en = 1'b0;
    check("fill_w5_ack", wbm_ack_o, 1);
    check("fill_w5_level_kept", level_o, 4);
    master_idle();
    tick();
    check("fill_w5_ack_1cyc", wbm_ack_o, 0);
    slv_ack_en = 1'b1;
    wait_idle_slave("fill");
    check("fill_xfers", slv_done_n - base, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_order_adr%0d", i), log_adr[base + i], 32'h40 + 32'(4 * i));
      check($sformatf("fill_order_dat%0d", i), log_dat[base + i], 32'(i + 1));
    end

    // Read ordered behind two posted writes
    base = slv_done_n;
    post_write(32'h10, 32'hA5A5_A5A5, "ord_w0");
    post_write(32'h14, 32'h5A5A_5A5A, "ord_w1");
    start_read(32'h10);
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      tick();
      n++;
      got = wbm_ack_o | wbm_err_o;
    end
    check("ord_rd_seen", got, 1);
    check("ord_rd_ack", wbm_ack_o, 1);
    check("ord_rd_err", wbm_err_o, 0);
    check("ord_rd_dat", wbm_dat_o, 32'hA5A5_A5A5);
    master_idle();
    tick();
    check("ord_xfers", slv_done_n - base, 3);
    check("ord_s0", {log_we[base], log_adr[base]}, {1'b1, 32'h10});
    check("ord_s1", {log_we[base + 1], log_adr[base + 1]}, {1'b1, 32'h14});
    check("ord_s2", {log_we[base + 2], log_adr[base + 2]}, {1'b0, 32'h10});

    // Read latency with an empty buffer and zero-wait slave
    start_read(32'h14);
    tick();
    check("lat_c1", wbm_ack_o, 0);
    tick();
    check("lat_c2", wbm_ack_o, 0);
    tick();
    check("lat_c3_ack", wbm_ack_o, 1);
    check("lat_c3_dat", wbm_dat_o, 32'h5A5A_5A5A);
    master_idle();
    tick();
    check("lat_ack_1cyc", wbm_ack_o, 0);

    // Slave error on a read
    slv_err_all = 1'b1;
    start_read(32'h20);
    tick();
    tick();
    tick();
    check("rerr_err", wbm_err_o, 1);
    check("rerr_ack", wbm_ack_o, 0);
    check("rerr_dat", wbm_dat_o, 0);
    master_idle();
    slv_err_all = 1'b0;
    tick();
    check("rerr_err_1cyc", wbm_err_o, 0);
    check("rerr_no_wr_err", wr_err_o, 0);

    // Posted-write error on the second of three writes
    base = slv_done_n;
    slv_err_idx = base + 1;
    post_write(32'h60, 32'h6, "perr_w0");
    post_write(32'h64, 32'h7, "perr_w1");
    post_write(32'h68, 32'h8, "perr_w2");
    wait_idle_slave("perr");
    slv_err_idx = -1;
    check("perr_set", wr_err_o, 1);
    check("perr_popped", slv_done_n - base, 3);
    check("perr_level", level_o, 0);
    wr_err_clr_i = 1'b1;
    tick();
    wr_err_clr_i = 1'b0;
    check("perr_clr", wr_err_o, 0);
    slv_ack_en = 1'b0;
    post_write(32'h6C, 32'h9, "perr_w3");
    check("perr_w3_inflight", wbs_cyc_o, 1);
    slv_err_all = 1'b1;
    wr_err_clr_i = 1'b1;
    tick();
    slv_err_all = 1'b0;
    wr_err_clr_i = 1'b0;
    slv_ack_en = 1'b1;
    check("perr_set_wins", wr_err_o, 1);
    check("perr_w3_popped", level_o, 0);
    wr_err_clr_i = 1'b1;
    tick();
    wr_err_clr_i = 1'b0;
    check("perr_clr2", wr_err_o, 0);

`ifdef MPSOC_MSI_WB_BUFFER_TIMEOUT_EN
    // Slave that never answers a read
    slv_ack_en = 1'b0;
    start_read(32'h30);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = wbm_err_o | wbm_ack_o;
      if (!got && wbs_cyc_o) n++;
    end
    check("to_err", wbm_err_o, 1);
    check("to_ack", wbm_ack_o, 0);
    check("to_cycles", n, 16);
    check("to_cyc_drop", wbs_cyc_o, 0);
    master_idle();
    slv_ack_en = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
